// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM state type and width helper for the bin2bcd_disp converter.
package bin2bcd_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         NIB_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >> 1) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_disp_digit_adj.sv
// One BCD digit correction step for double-dabble: digits of 5 or more get +3 before the shift.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [NIB_W-1:0] digit,
    output logic [NIB_W-1:0] adj
);

    // Add-3 correction so the following left shift carries into the next decade.
    always_comb begin
        adj = digit;
        if (digit >= 4'd5) begin
            adj = digit + 4'd3;
        end else begin
            adj = digit;
        end
    end

endmodule

// File: rtl/bin2bcd_disp.sv
// Iterative binary-to-BCD converter packing digits for the seven-segment scan driver.
// Optional macro BIN2BCD_LZ_BLANK_EN blanks leading zero digits (the LSD is always shown).
module bin2bcd_disp
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W       = 12,
    parameter int DIGITS      = 4,
    parameter int DISP_DIGITS = 8,
    parameter int AUTO_RUN    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BIN_W-1:0]         bin_in,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [NIB_W*DISP_DIGITS-1:0] disp_data
);

    localparam int CNT_W  = clog2(BIN_W + 32'sd1);
    localparam int BCD_W  = NIB_W * DIGITS;
    localparam int DISP_W = NIB_W * DISP_DIGITS;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [BIN_W-1:0]   shift_r;
    logic [BIN_W-1:0]   last_bin_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [BCD_W-1:0]   bcd_adj_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;
    logic               overflow_r;
    logic [DISP_W-1:0]  disp_r;
    logic [DISP_W-1:0]  disp_nxt_s;
    logic               accept_s;
    logic               last_iter_s;
    logic               lead_s;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit (bcd_r[g*NIB_W +: NIB_W]),
                .adj   (bcd_adj_s[g*NIB_W +: NIB_W])
            );
        end
    endgenerate

    // In auto-run mode a new value is detected by comparing against the last converted one.
    assign accept_s    = (AUTO_RUN == 32'sd1) ? (bin_in != last_bin_r) : start;
    assign last_iter_s = (cnt_r == CNT_W'(BIN_W - 32'sd1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_iter_s) begin
                    state_nxt_s = FORMAT;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            FORMAT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Display word assembly; overflow forces all 9s, which are never blanked.
    always_comb begin
        disp_nxt_s = {DISP_DIGITS{BLANK_CODE}};
        lead_s     = 1'b1;
        for (int i = DIGITS - 32'sd1; i >= 32'sd0; i--) begin
            if (ovf_r) begin
                disp_nxt_s[i*NIB_W +: NIB_W] = 4'd9;
`ifdef BIN2BCD_LZ_BLANK_EN
            end else if (lead_s && (i > 32'sd0) && (bcd_r[i*NIB_W +: NIB_W] == 4'd0)) begin
                disp_nxt_s[i*NIB_W +: NIB_W] = BLANK_CODE;
`endif
            end else begin
                disp_nxt_s[i*NIB_W +: NIB_W] = bcd_r[i*NIB_W +: NIB_W];
                lead_s = 1'b0;
            end
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= '0;
            last_bin_r <= '0;
            bcd_r      <= '0;
            cnt_r      <= '0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            disp_r     <= {DISP_DIGITS{BLANK_CODE}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shift_r    <= bin_in;
                        last_bin_r <= bin_in;
                        bcd_r      <= '0;
                        cnt_r      <= '0;
                        ovf_r      <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                SHIFT: begin
                    // A bit leaving the top digit means the value no longer fits.
                    bcd_r   <= {bcd_adj_s[BCD_W-2:0], shift_r[BIN_W-1]};
                    shift_r <= shift_r << 1'b1;
                    ovf_r   <= ovf_r | bcd_adj_s[BCD_W-1];
                    cnt_r   <= cnt_r + CNT_W'(1'b1);
                end
                FORMAT: begin
                    disp_r     <= disp_nxt_s;
                    overflow_r <= ovf_r;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign overflow  = overflow_r;
    assign disp_data = disp_r;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Directed self-checking bench for bin2bcd_disp: default, three-digit and auto-run instances.
module tb_bin2bcd_disp;

    logic        clk;
    logic        rst_n;
    logic [11:0] bin_in, bin3, bin_a;
    logic        start, start3, start_a;
    logic        busy, busy3, busy_a;
    logic        done, done3, done_a;
    logic        overflow, overflow3, overflow_a;
    logic [31:0] disp, disp3, disp_a;

    int total = 0;
    int bad   = 0;

`ifdef BIN2BCD_LZ_BLANK_EN
    localparam logic [31:0] EXP_7   = 32'hFFFFFFF7;
    localparam logic [31:0] EXP_0   = 32'hFFFFFFF0;
    localparam logic [31:0] EXP_1   = 32'hFFFFFFF1;
    localparam logic [31:0] EXP_42  = 32'hFFFFFF42;
    localparam logic [31:0] EXP_56  = 32'hFFFFFF56;
    localparam logic [31:0] EXP_100 = 32'hFFFFF100;
`else
    localparam logic [31:0] EXP_7   = 32'hFFFF0007;
    localparam logic [31:0] EXP_0   = 32'hFFFF0000;
    localparam logic [31:0] EXP_1   = 32'hFFFF0001;
    localparam logic [31:0] EXP_42  = 32'hFFFF0042;
    localparam logic [31:0] EXP_56  = 32'hFFFF0056;
    localparam logic [31:0] EXP_100 = 32'hFFFF0100;
`endif

    bin2bcd_disp dut (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .start(start),
        .busy(busy), .done(done), .overflow(overflow), .disp_data(disp)
    );

    bin2bcd_disp #(.DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin3), .start(start3),
        .busy(busy3), .done(done3), .overflow(overflow3), .disp_data(disp3)
    );

    bin2bcd_disp #(.AUTO_RUN(1)) dut_auto (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_a), .start(start_a),
        .busy(busy_a), .done(done_a), .overflow(overflow_a), .disp_data(disp_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion on the default instance; lat = cycles from accept edge to done.
    task automatic run_conv(input logic [11:0] value, output int lat, output int bcnt);
        bin_in = value;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 60) begin
            tick();
            lat++;
            if (!done && busy) bcnt++;
        end
    endtask

    task automatic run_conv3(input logic [11:0] value, output int lat);
        bin3   = value;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        lat = 0;
        while (!done3 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (disp !== 32'hFFFFFFFF) begin bad++; $display("FAIL reset_disp got=%h exp=%h", disp, 32'hFFFFFFFF); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat, bcnt;
        run_conv(12'd1234, lat, bcnt);
        total++; if (lat !== 13) begin bad++; $display("FAIL basic_latency got=%0d exp=13", lat); end
        total++; if (bcnt !== 13) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=13", bcnt); end
        total++; if (disp !== 32'hFFFF1234) begin bad++; $display("FAIL basic_disp got=%h exp=%h", disp, 32'hFFFF1234); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_small_values();
        int lat, bcnt;
        run_conv(12'd7, lat, bcnt);
        total++; if (disp !== EXP_7) begin bad++; $display("FAIL small7_disp got=%h exp=%h", disp, EXP_7); end
        tick();
        run_conv(12'd0, lat, bcnt);
        total++; if (disp !== EXP_0) begin bad++; $display("FAIL zero_disp got=%h exp=%h", disp, EXP_0); end
        tick();
        run_conv(12'd4095, lat, bcnt);
        total++; if (disp !== 32'hFFFF4095) begin bad++; $display("FAIL max_disp got=%h exp=%h", disp, 32'hFFFF4095); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL max_ovf got=%b exp=0", overflow); end
        tick();
    endtask

    task automatic test_overflow();
        int lat;
        logic [31:0] held;
        run_conv3(12'd4095, lat);
        total++; if (lat !== 13) begin bad++; $display("FAIL ovf_latency got=%0d exp=13", lat); end
        total++; if (disp3 !== 32'hFFFFF999) begin bad++; $display("FAIL ovf_disp got=%h exp=%h", disp3, 32'hFFFFF999); end
        total++; if (overflow3 !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow3); end
        held = disp3;
        tick();
        bin3   = 12'd999;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++; if (overflow3 !== 1'b1) begin bad++; $display("FAIL ovf_held got=%b exp=1", overflow3); end
        total++; if (disp3 !== held) begin bad++; $display("FAIL ovf_disp_held got=%h exp=%h", disp3, held); end
        total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL ovf_busy got=%b exp=1", busy3); end
        lat = 0;
        while (!done3 && lat < 60) begin tick(); lat++; end
        total++; if (disp3 !== 32'hFFFFF999) begin bad++; $display("FAIL d999_disp got=%h exp=%h", disp3, 32'hFFFFF999); end
        total++; if (overflow3 !== 1'b0) begin bad++; $display("FAIL d999_ovf got=%b exp=0", overflow3); end
        tick();
    endtask

    task automatic test_start_ignored();
        int done_cnt, done_at, lat, bcnt;
        done_cnt = 0;
        done_at  = -1;
        bin_in = 12'd4095;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                bin_in = 12'd1;
                start  = 1'b1;
            end
            tick();
            if (c == 5) start = 1'b0;
            if (done) begin done_cnt++; done_at = c; end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt); end
        total++; if (done_at !== 13) begin bad++; $display("FAIL ignore_done_cycle got=%0d exp=13", done_at); end
        total++; if (disp !== 32'hFFFF4095) begin bad++; $display("FAIL ignore_disp got=%h exp=%h", disp, 32'hFFFF4095); end
        run_conv(12'd1, lat, bcnt);
        total++; if (disp !== EXP_1) begin bad++; $display("FAIL after_ignore_disp got=%h exp=%h", disp, EXP_1); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        run_conv(12'd1234, lat, bcnt);
        run_conv(12'd56, lat, bcnt);
        total++; if (lat !== 13) begin bad++; $display("FAIL b2b_latency got=%0d exp=13", lat); end
        total++; if (disp !== EXP_56) begin bad++; $display("FAIL b2b_disp got=%h exp=%h", disp, EXP_56); end
        tick();
    endtask

    task automatic test_reset_mid();
        int done_cnt, lat, bcnt;
        done_cnt = 0;
        bin_in = 12'd1234;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        total++; if (disp !== 32'hFFFFFFFF) begin bad++; $display("FAIL midrst_disp got=%h exp=%h", disp, 32'hFFFFFFFF); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) done_cnt++;
        end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt); end
        run_conv(12'd42, lat, bcnt);
        total++; if (disp !== EXP_42) begin bad++; $display("FAIL midrst_next_disp got=%h exp=%h", disp, EXP_42); end
        tick();
    endtask

    task automatic test_auto_run();
        int done_cnt;
        done_cnt = 0;
        bin_a = 12'd100;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done_a) done_cnt++;
        end
        bin_a = 12'd2500;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done_a) done_cnt++;
        end
        total++; if (disp_a !== EXP_100) begin bad++; $display("FAIL auto_first_disp got=%h exp=%h", disp_a, EXP_100); end
        for (int i = 0; i < 26; i++) begin
            tick();
            if (done_a) done_cnt++;
        end
        total++; if (done_cnt !== 2) begin bad++; $display("FAIL auto_done_count got=%0d exp=2", done_cnt); end
        total++; if (disp_a !== 32'hFFFF2500) begin bad++; $display("FAIL auto_disp got=%h exp=%h", disp_a, 32'hFFFF2500); end
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done_a) done_cnt++;
        end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL auto_idle_done got=%0d exp=0", done_cnt); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL auto_idle_busy got=%b exp=0", busy_a); end
        total++; if (overflow_a !== 1'b0) begin bad++; $display("FAIL auto_ovf got=%b exp=0", overflow_a); end
    endtask

    initial begin
        rst_n   = 1'b0;
        bin_in  = 12'd0;
        bin3    = 12'd0;
        bin_a   = 12'd0;
        start   = 1'b0;
        start3  = 1'b0;
        start_a = 1'b0;
        test_reset();
        test_basic();
        test_small_values();
        test_overflow();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_auto_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
